rightmost_bits_pipeline: RTL
============================

// Module: rightmost_bits_pipeline
// PURPOSE
//  Pipelined, runtime-selectable rightmost-bit manipulation unit (Hacker's Delight 2-1).
//  One word per cycle through a 2-stage valid/ready pipeline. Each word carries a 3-bit opcode.
//  Output is the result plus a zero-test flag, so one instance also serves power-of-two and (2^n)-1 detection.
//  Sits between streaming datapath stages. Accepts backpressure without loss.
// PARAMETERS
//  WORD_WIDTH  8  data word width in bits, >= 2
// PORTS
//  clock      in   1           single clock; all state on rising edge
//  reset_n    in   1           asynchronous, active-low reset
//  in_valid   in   1           input word/op offered
//  in_ready   out  1           input accepted when in_valid & in_ready
//  in_word    in   WORD_WIDTH  operand x
//  in_op      in   3           operation select (see BEHAVIOUR)
//  out_valid  out  1           result available
//  out_ready  in   1           consumer accepts when out_valid & out_ready
//  out_word   out  WORD_WIDTH  result
//  out_zero   out  1           1 when out_word == 0
//  zero_count out  WORD_WIDTH  only with RIGHTMOST_BITS_ZERO_COUNT_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Ops, mod 2^WORD_WIDTH, all widths WORD_WIDTH:
//    0 x&(x-1) rightmost 1 off      1 x|(x+1) rightmost 0 on
//    2 x&(x+1) trailing 1s off      3 x|(x-1) trailing 0s on
//    4 x&(-x) isolate rightmost 1   5 ~x&(x+1) isolate rightmost 0
//    6 ~x&(x-1) mask trailing 0s    7 x^(x+1) mask rightmost 0 + trailing 1s
//  - Stage 1 registers {in_word,in_op}. Stage 2 registers {result,zero}.
//  - Latency is 2 cycles from accept to out_valid with no backpressure. Throughput is 1/cycle.
//  - Stage k loads when it is empty or its contents leave this cycle. in_ready = !s1_valid | s2_loads.
//  - in_ready is combinational from out_ready; no combinational path from in_valid to any output.
//  - Once out_valid is high, out_word and out_zero hold stable until the transfer completes.
//  - Simultaneous accept and emit in the same cycle is legal; no bubble is inserted.
//  - Full condition: both stages valid and out_ready=0 -> in_ready=0. No word is dropped or duplicated; order is preserved.
//  - Wrap-around: x=0 with op0 gives 0. x=all-1s with op1 gives all-1s. Arithmetic wraps; there is no carry out.
//  - Reset (async assert, any cycle): s1_valid=s2_valid=0, out_valid=0, out_word=0, out_zero=0, zero_count=0, in_ready=1 at the first edge after deassert.
//  - Reset mid-operation discards in-flight words.
// CONFIGURATION
//  - RIGHTMOST_BITS_ZERO_COUNT_EN defined: adds port zero_count.
//    zero_count increments on each output transfer with out_zero=1. It saturates at all-1s and is cleared only by reset.
//  - Macro undefined: port and counter are absent. All other behaviour is identical.
// STRUCTURE
//  - Package rightmost_bits_pkg holds the op_t 3-bit enum (OP_OFF_RM1 ... OP_MASK_RM0_T1) and OP_WIDTH=3.
//  - Sub-module rightmost_bits_op: purely combinational (x, op) -> result, parametrised by WORD_WIDTH.
//    Stage 2 instantiates it once. All handshake and registers stay in the top module.
// TESTING (WORD_WIDTH=8, out_ready=1 unless stated)
//  1 ops on 0xA7/0x58: op2 0xA7->0xA0; op0 0x58->0x50; op4 0x58->0x08; op1 0xA7->0xAF;
//    op7 0xA7->0x0F; op6 0x58->0x07. Each appears 2 cycles after accept.
//  2 zero/edges: op2 0x7F->0x00 zero=1; op2 0xFF->0x00 zero=1; op0 0x00->0x00 zero=1; op1 0xFF->0xFF zero=0; op4 0x00->0x00.
//  3 backpressure: out_ready=0 for 6 cycles while 4 words are offered.
//    in_ready falls after 2 accepts; on release, outputs appear in order and the remaining 2 are accepted.
//  4 streaming: 100 random words/ops with random out_ready. Scoreboard matches a reference model; out_word is stable while stalled.
//  5 reset: assert reset_n=0 with 2 words in flight. out_valid=0 immediately, no stale output afterwards, in_ready=1.
//  6 macro on: 300 zero-result transfers -> zero_count saturates at 0xFF. A stalled zero result is counted once.

Source files
------------

// File: rtl/rightmost_bits_pkg.sv
// Shared types for the rightmost-bit manipulation pipeline.
// Holds the opcode enum and opcode width.
package rightmost_bits_pkg;

    localparam int OP_WIDTH = 3;

    typedef enum logic [OP_WIDTH-1:0] {
        OP_OFF_RM1     = 3'd0,
        OP_ON_RM0      = 3'd1,
        OP_OFF_T1      = 3'd2,
        OP_ON_T0       = 3'd3,
        OP_ISO_RM1     = 3'd4,
        OP_ISO_RM0     = 3'd5,
        OP_MASK_T0     = 3'd6,
        OP_MASK_RM0_T1 = 3'd7
    } op_t;

endpackage

// File: rtl/rightmost_bits_op.sv
// Combinational rightmost-bit operator: (x, op) -> result.
// Ports: x (operand), op (op_t select), result (WORD_WIDTH, wraps).
module rightmost_bits_op
    import rightmost_bits_pkg::*;
#(
    parameter int WORD_WIDTH = 8
) (
    input  logic [WORD_WIDTH-1:0] x,
    input  op_t                   op,
    output logic [WORD_WIDTH-1:0] result
);

    localparam logic [WORD_WIDTH-1:0] ONE = {{(WORD_WIDTH-1){1'b0}}, 1'b1};

    logic [WORD_WIDTH-1:0] xm1;
    logic [WORD_WIDTH-1:0] xp1;
    logic [WORD_WIDTH-1:0] neg;

    assign xm1 = x - ONE;
    assign xp1 = x + ONE;
    assign neg = ~x + ONE;

    always_comb begin
        result = '0;
        unique case (op)
            OP_OFF_RM1:     result = x & xm1;
            OP_ON_RM0:      result = x | xp1;
            OP_OFF_T1:      result = x & xp1;
            OP_ON_T0:       result = x | xm1;
            OP_ISO_RM1:     result = x & neg;
            OP_ISO_RM0:     result = ~x & xp1;
            OP_MASK_T0:     result = ~x & xm1;
            OP_MASK_RM0_T1: result = x ^ xp1;
            default:        result = '0;
        endcase
    end

endmodule

// File: rtl/rightmost_bits_pipeline.sv
// 2-stage valid/ready pipeline applying a rightmost-bit op per word.
// Ports: clock, reset_n (async low), in_valid/in_ready/in_word/in_op,
// out_valid/out_ready/out_word/out_zero; zero_count when
// RIGHTMOST_BITS_ZERO_COUNT_EN is defined (saturating zero-result count).
module rightmost_bits_pipeline
    import rightmost_bits_pkg::*;
#(
    parameter int WORD_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] in_word,
    input  logic [OP_WIDTH-1:0]   in_op,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] out_word,
    output logic                  out_zero
`ifdef RIGHTMOST_BITS_ZERO_COUNT_EN
    ,
    output logic [WORD_WIDTH-1:0] zero_count
`endif
);

    logic                  s1_valid;
    logic [WORD_WIDTH-1:0] s1_word;
    op_t                   s1_op;

    logic                  s2_valid;
    logic [WORD_WIDTH-1:0] s2_word;
    logic                  s2_zero;

    logic                  s2_loads;
    logic [WORD_WIDTH-1:0] op_result;

    // Stage 2 frees up when empty or draining this cycle; stage 1
    // can then always advance, so in_ready follows s2_loads.
    assign s2_loads = !s2_valid | out_ready;
    assign in_ready = !s1_valid | s2_loads;

    rightmost_bits_op #(
        .WORD_WIDTH(WORD_WIDTH)
    ) u_op (
        .x      (s1_word),
        .op     (s1_op),
        .result (op_result)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_word  <= '0;
            s1_op    <= OP_OFF_RM1;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_word <= in_word;
                s1_op   <= op_t'(in_op);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
            s2_word  <= '0;
            s2_zero  <= 1'b0;
        end else if (s2_loads) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_word <= op_result;
                s2_zero <= (op_result == '0);
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_word  = s2_word;
    assign out_zero  = s2_zero;

`ifdef RIGHTMOST_BITS_ZERO_COUNT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            zero_count <= '0;
        end else if (s2_valid && out_ready && s2_zero
                     && (zero_count != '1)) begin
            zero_count <= zero_count + 1'b1;
        end
    end
`endif

endmodule
